// File: rtl/cb_rle_encoder.sv
// cb_rle_encoder
// Run-length / magnitude-category encoder for one 8x8 block of quantized Cb
// coefficients. A block is captured on enable. The encoder then emits one DC
// difference symbol, walks the AC coefficients in zigzag order emitting
// (run, size, amp) symbols plus ZRL symbols for long zero runs, and closes
// the block with EOB unless the last zigzag coefficient is nonzero.
// Symbols use a valid/ready handshake. Everything in flight holds while the
// downstream stage stalls.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for enable; captures the block when it arrives
// FIND     | locates the highest nonzero zigzag index (last_nz)
// EMIT_DC  | presents the DC difference symbol; prev_dc updates on accept
// SCAN_AC  | steps zigzag index 1..last_nz, emitting AC and ZRL symbols
// EMIT_EOB | presents end-of-block (run 0, size 0, amp 0)
// DONE     | one-cycle block_done pulse, then back to IDLE

module cb_rle_encoder (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic signed [0:7][0:7][10:0]  Q,
    input  logic                          dc_clear,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic                          is_dc,
    output logic [3:0]                    run,
    output logic [3:0]                    size,
    output logic [10:0]                   amp,
    output logic                          busy,
    output logic                          block_done
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FIND     = 3'd1,
        EMIT_DC  = 3'd2,
        SCAN_AC  = 3'd3,
        EMIT_EOB = 3'd4,
        DONE     = 3'd5
    } state_t;

    // Zigzag index -> row-major position (row*8 + col).
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    // Magnitude category: bit length of |v|, 0 for v == 0.
    function automatic logic [3:0] mag_size(input logic signed [11:0] v);
        logic [11:0] m;
        logic [3:0]  s;
        m = v[11] ? 12'(-v) : 12'(v);
        s = 4'd0;
        for (int b = 0; b < 12; b++) begin
            if (m[b]) s = 4'(b + 1);
        end
        return s;
    endfunction

    // Amplitude bits: v itself when positive, (v - 1) masked to s bits when
    // negative (ones-complement style used by JPEG).
    function automatic logic [10:0] mag_amp(input logic signed [11:0] v,
                                            input logic [3:0] s);
        logic [10:0] t;
        logic [10:0] mask;
        t    = v[11] ? 11'(v - 12'sd1) : v[10:0];
        mask = 11'((12'd1 << s) - 12'd1);
        return t & mask;
    endfunction

    state_t             state, state_nxt;
    logic [0:63][10:0]  coef_buf;
    logic [10:0]        prev_dc;
    logic [5:0]         last_nz;
    logic [5:0]         last_nz_calc;
    logic [5:0]         k;
    logic [3:0]         zcnt;
    logic [10:0]        ac_coef;
    logic               ac_nonzero;
    logic signed [11:0] dc_diff;
    logic signed [11:0] sym_val;
    logic               step_ac;

    assign ac_coef    = coef_buf[ZZ[k]];
    assign ac_nonzero = (ac_coef != 11'd0);
    assign dc_diff    = $signed({coef_buf[0][10], coef_buf[0]})
                      - $signed({prev_dc[10], prev_dc});
    // SCAN_AC advances on every cycle that has no symbol, or when the symbol
    // presented is taken.
    assign step_ac    = (state == SCAN_AC) && (!out_valid || out_ready);

    // Highest zigzag index 1..63 holding a nonzero coefficient, 0 if none.
    always_comb begin
        last_nz_calc = 6'd0;
        for (int i = 1; i < 64; i++) begin
            if (coef_buf[ZZ[i]] != 11'd0) last_nz_calc = 6'(i);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and symbol output decode.
    always_comb begin
        state_nxt  = state;
        out_valid  = 1'b0;
        is_dc      = 1'b0;
        run        = 4'd0;
        sym_val    = 12'sd0;
        busy       = 1'b0;
        block_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable) state_nxt = FIND;
            end
            FIND: begin
                busy      = 1'b1;
                state_nxt = EMIT_DC;
            end
            EMIT_DC: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                is_dc     = 1'b1;
                sym_val   = dc_diff;
                if (out_ready) state_nxt = (last_nz == 6'd0) ? EMIT_EOB : SCAN_AC;
            end
            SCAN_AC: begin
                busy = 1'b1;
                if (ac_nonzero) begin
                    out_valid = 1'b1;
                    run       = zcnt;
                    sym_val   = {ac_coef[10], ac_coef};
                    if (out_ready && (k == last_nz))
                        state_nxt = (last_nz == 6'd63) ? DONE : EMIT_EOB;
                end else if (zcnt == 4'd15) begin
                    // Sixteenth consecutive zero: ZRL.
                    out_valid = 1'b1;
                    run       = 4'd15;
                end
            end
            EMIT_EOB: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = DONE;
            end
            DONE: begin
                block_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // sym_val is zero whenever out_valid is low, so size and amp are too.
        size = mag_size(sym_val);
        amp  = mag_amp(sym_val, size);
    end

    // Block buffer, DC predictor, last_nz, zigzag index and zero-run counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coef_buf <= '0;
            prev_dc  <= 11'd0;
            last_nz  <= 6'd0;
            k        <= 6'd0;
            zcnt     <= 4'd0;
        end else begin
            if (state == IDLE && enable) coef_buf <= Q;
            if (state == FIND) last_nz <= last_nz_calc;
            // A frame-start clear outranks a simultaneous DC acceptance.
            if (dc_clear)
                prev_dc <= 11'd0;
            else if (state == EMIT_DC && out_ready)
                prev_dc <= coef_buf[0];
            if (state == EMIT_DC) begin
                k    <= 6'd1;
                zcnt <= 4'd0;
            end else if (step_ac) begin
                k <= k + 6'd1;
                if (ac_nonzero || zcnt == 4'd15) zcnt <= 4'd0;
                else                             zcnt <= zcnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_cb_rle_encoder.sv
// tb_cb_rle_encoder
// Scoreboard bench: each block's expected symbol list is pushed when the
// block is driven and popped as the encoder hands symbols over.

module tb_cb_rle_encoder;

    typedef logic [0:7][0:7][10:0] blk_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        dc_clear = 1'b0;
    logic        out_ready = 1'b1;
    blk_t        q_drv = '0;
    logic        out_valid, is_dc, busy, block_done;
    logic [3:0]  run, size;
    logic [10:0] amp;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_acc = 0;
    int          mdl_prev = 0;
    int          ready_mode = 0;
    logic        done_seen = 1'b0;
    logic [19:0] sb [$];
    int          zz_r [64];
    int          zz_c [64];

    cb_rle_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .Q          (q_drv),
        .dc_clear   (dc_clear),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .is_dc      (is_dc),
        .run        (run),
        .size       (size),
        .amp        (amp),
        .busy       (busy),
        .block_done (block_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] mk(input int dc, input int r, input int s, input int a);
        return {1'(dc), 4'(r), 4'(s), 11'(a)};
    endfunction

    function automatic int sx(input logic [10:0] x);
        logic signed [10:0] t;
        t = x;
        return int'(t);
    endfunction

    function automatic logic [19:0] enc(input int dc, input int r, input int v);
        int m, s, a;
        m = (v < 0) ? -v : v;
        s = 0;
        while (m > 0) begin
            m = m >> 1;
            s++;
        end
        a = (v > 0) ? v : ((v - 1) & ((1 << s) - 1));
        return mk(dc, r, s, a);
    endfunction

    task automatic model_push(input blk_t b, input bit clr);
        int v, last, zr;
        sb.push_back(enc(1, 0, sx(b[0][0]) - mdl_prev));
        last = 0;
        for (int i = 1; i < 64; i++)
            if (sx(b[zz_r[i]][zz_c[i]]) != 0) last = i;
        zr = 0;
        for (int i = 1; i <= last; i++) begin
            v = sx(b[zz_r[i]][zz_c[i]]);
            if (v == 0) begin
                zr++;
                if (zr == 16) begin
                    sb.push_back(mk(0, 15, 0, 0));
                    zr = 0;
                end
            end else begin
                sb.push_back(enc(0, zr, v));
                zr = 0;
            end
        end
        if (last < 63) sb.push_back(mk(0, 0, 0, 0));
        mdl_prev = clr ? 0 : sx(b[0][0]);
    endtask

    task automatic send_block(input blk_t b, input bit use_model, input bit clr,
                              input bit poke_busy, input bit poke_done);
        int i;
        if (use_model) model_push(b, clr);
        @(negedge clk); #1;
        done_seen = 1'b0;
        q_drv  = b;
        enable = 1'b1;
        @(negedge clk); #1;
        enable = 1'b0;
        chk("find_quiet", out_valid, 0);
        chk("busy_find", busy, 1);
        @(negedge clk); #1;
        chk("dc_latency", out_valid, 1);
        chk("dc_flag", is_dc, 1);
        if (clr) dc_clear = 1'b1;
        @(negedge clk); #1;
        dc_clear = 1'b0;
        if (poke_busy) begin
            q_drv  = {64{11'h2AA}};
            enable = 1'b1;
            @(negedge clk); #1;
            enable = 1'b0;
        end
        for (i = 0; i < 3000 && !done_seen; i++) begin
            @(negedge clk); #1;
        end
        chk("done_seen", done_seen, 1);
        chk("busy_done", busy, 0);
        if (poke_done) begin
            q_drv  = {64{11'h155}};
            enable = 1'b1;
        end
        @(negedge clk); #1;
        enable = 1'b0;
        if (poke_done) begin
            repeat (4) @(negedge clk);
            #1;
            chk("done_enable_ignored", busy, 0);
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk); #1;
        dc_clear = 1'b1;
        @(negedge clk); #1;
        dc_clear = 1'b0;
        mdl_prev = 0;
    endtask

    // Monitor: handshake, scoreboard pop, stall stability, idle fields, done pulse.
    initial begin : monitor
        logic [20:0] cur, held;
        logic        stall_prev, done_expect;
        logic [19:0] exp_sym;
        int          cyc;
        stall_prev  = 1'b0;
        done_expect = 1'b0;
        held        = '0;
        cyc         = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev  = 1'b0;
                done_expect = 1'b0;
            end else begin
                cur = {out_valid, is_dc, run, size, amp};
                chk("block_done", block_done, done_expect);
                if (block_done) done_seen = 1'b1;
                done_expect = 1'b0;
                if (stall_prev) chk("stall_hold", cur, held);
                if (!out_valid) chk("idle_fields", cur[19:0], 0);
                cyc++;
                out_ready = (ready_mode == 0) ? 1'b1 : cyc[0];
                if (out_valid && out_ready) begin
                    chk("sb_depth", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        exp_sym = sb.pop_front();
                        chk("symbol", cur[19:0], exp_sym);
                        n_acc++;
                        if (sb.size() == 0) done_expect = 1'b1;
                    end
                end
                stall_prev = out_valid && !out_ready;
                held       = cur;
            end
        end
    end

    initial begin : stim
        blk_t b, ramp;
        int   idx, base, i;

        idx = 0;
        for (int s = 0; s < 15; s++) begin
            if (s % 2 == 0) begin
                for (int r = (s < 8 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
                    zz_r[idx] = r; zz_c[idx] = s - r; idx++;
                end
            end else begin
                for (int r = (s > 7 ? s - 7 : 0); r <= (s < 8 ? s : 7); r++) begin
                    zz_r[idx] = r; zz_c[idx] = s - r; idx++;
                end
            end
        end
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                idx = r * 8 + c;
                ramp[r][c] = (r + c < 6 && idx % 3 != 1) ? 11'(idx - 10) : 11'd0;
            end

        #1;
        chk("rst_outputs", {out_valid, is_dc, run, size, amp, busy, block_done}, 0);
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;

        // All-zero block: DC size 0, then EOB.
        b = '0;
        sb.push_back(mk(1, 0, 0, 0));
        sb.push_back(mk(0, 0, 0, 0));
        send_block(b, 0, 0, 0, 0);
        mdl_prev = 0;

        // Only the last zigzag coefficient set: three ZRLs, run 14, no EOB.
        b = '0;
        b[7][7] = 11'd1;
        sb.push_back(mk(1, 0, 0, 0));
        repeat (3) sb.push_back(mk(0, 15, 0, 0));
        sb.push_back(mk(0, 14, 1, 1));
        send_block(b, 0, 0, 0, 0);
        mdl_prev = 0;

        // DC prediction across two blocks.
        b = '0;
        b[0][0] = 11'd5;
        sb.push_back(mk(1, 0, 3, 5));
        sb.push_back(mk(0, 0, 0, 0));
        send_block(b, 0, 0, 0, 0);
        b[0][0] = 11'd3;
        sb.push_back(mk(1, 0, 2, 1));
        sb.push_back(mk(0, 0, 0, 0));
        send_block(b, 0, 0, 0, 0);

        // Clear in IDLE, then DC difference is against zero.
        pulse_clear();
        b[0][0] = 11'd7;
        sb.push_back(mk(1, 0, 3, 7));
        sb.push_back(mk(0, 0, 0, 0));
        send_block(b, 0, 0, 0, 0);
        mdl_prev = 7;

        // Checkerboard of extremes from prev_dc 0.
        pulse_clear();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                b[r][c] = ((r + c) % 2 == 0) ? 11'd1023 : 11'h400;
        base = n_acc;
        send_block(b, 1, 0, 0, 0);
        chk("checker_count", n_acc - base, 64);

        // Ramp with full-rate and throttled downstream.
        send_block(ramp, 1, 0, 0, 0);
        ready_mode = 1;
        send_block(ramp, 1, 0, 0, 0);
        ready_mode = 0;

        // Enable while busy, plus dc_clear coincident with DC acceptance.
        send_block(ramp, 1, 1, 1, 0);
        // Enable during DONE must not start a block.
        send_block(ramp, 1, 0, 0, 1);

        // Sparse random blocks, alternating downstream behaviour.
        for (int n = 0; n < 8; n++) begin
            for (int p = 0; p < 64; p++) begin
                idx = 0;
                if ($urandom_range(7, 0) == 0 || p == 0) begin
                    idx = int'($urandom_range(2047, 0)) - 1024;
                    if (idx == 0) idx = 1;
                end
                b[p / 8][p % 8] = 11'(idx);
            end
            ready_mode = n % 2;
            send_block(b, 1, 0, 0, 0);
        end
        ready_mode = 0;

        // Reset in the middle of SCAN_AC.
        model_push(ramp, 0);
        @(negedge clk); #1;
        q_drv  = ramp;
        enable = 1'b1;
        base   = n_acc;
        @(negedge clk); #1;
        enable = 1'b0;
        for (i = 0; i < 200 && (n_acc - base) < 3; i++) begin
            @(negedge clk); #1;
        end
        chk("scan_reached", (n_acc - base) >= 3, 1);
        rst = 1'b1;
        #1;
        chk("rst_async_outputs", {out_valid, is_dc, run, size, amp, busy, block_done}, 0);
        sb.delete();
        mdl_prev = 0;
        @(negedge clk); #1;
        rst = 1'b0;
        b = '0;
        sb.push_back(mk(1, 0, 0, 0));
        sb.push_back(mk(0, 0, 0, 0));
        send_block(b, 0, 0, 0, 0);
        chk("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
